// File: rtl/vdc_hostwriter_if.sv
// Command, stream and VDC register-port signals of the host writer.
// The slave view belongs to the writer; the master view belongs to whatever drives it.
`timescale 1ns/1ps
interface vdc_hostwriter_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_count;
  logic [7:0]  cmd_fill;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        done;
  logic        error;
  logic        busy;
  logic        bus_strobe;
  logic        vdc_cs;
  logic        vdc_rs;
  logic        vdc_we;
  logic [7:0]  vdc_dout;
  logic [7:0]  vdc_din;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_count, cmd_fill, in_valid, in_data,
           bus_strobe, vdc_din,
    output cmd_ready, in_ready, done, error, busy, vdc_cs, vdc_rs, vdc_we, vdc_dout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_count, cmd_fill, in_valid, in_data,
           bus_strobe, vdc_din,
    input  cmd_ready, in_ready, done, error, busy, vdc_cs, vdc_rs, vdc_we, vdc_dout
  );
endinterface

// File: rtl/vdc_hostwriter.sv
// Host-side VDC writer: turns WRITE/FILL block commands into register-port
// cycles (address select, status poll, data writes) without CPU help.
`timescale 1ns/1ps
module vdc_hostwriter #(
  parameter int POLL_LIMIT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  vdc_hostwriter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, POLL, SEL, WDAT, FETCH, FIN} state_t;

  // Step to run once the current bus access completes.
  typedef enum logic [3:0] {
    T_SEL18, T_HI, T_SEL19, T_LO, T_SEL31, T_PDATA,
    T_DATA, T_AFTER, T_CNT, T_PFIN, T_FIN
  } step_t;

  typedef struct packed {
    state_t     st;
    step_t      nx;
    logic [7:0] v;
  } go_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [7:0]  val_q, val_d;
  logic        cs_q, cs_d, rs_q, rs_d, we_q, we_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  cnt_q, cnt_d, cnt_eff;
  logic [15:0] poll_q, poll_d;
  logic        op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  fill_q, fill_d;
  logic        err_q, err_d;
  logic        pop;
  go_t         g;

  // Only the ready bit of the status byte matters.
  wire unused_status = &{1'b0, bus.vdc_din[6:0]};

  // Decode a step into the state that performs it, its data byte and the step after it.
  function automatic go_t go(step_t s, logic op, logic [15:0] a, logic [7:0] c, logic [7:0] f);
    go_t r;
    r.st = POLL; r.nx = T_FIN; r.v = 8'h00;
    case (s)
      T_SEL18: begin r.st = SEL;  r.v = 8'd18;   r.nx = T_HI;    end
      T_HI:    begin r.st = WDAT; r.v = a[15:8]; r.nx = T_SEL19; end
      T_SEL19: begin r.st = SEL;  r.v = 8'd19;   r.nx = T_LO;    end
      T_LO:    begin r.st = WDAT; r.v = a[7:0];  r.nx = T_SEL31; end
      T_SEL31: begin r.st = SEL;  r.v = 8'd31;   r.nx = T_PDATA; end
      T_PDATA: begin r.st = POLL; r.nx = T_DATA; end
      T_DATA:  begin r.st = op ? WDAT : FETCH; r.v = f; r.nx = T_AFTER; end
      T_AFTER: begin
        if (op) begin
          if (c > 8'd1) begin r.st = SEL; r.v = 8'd30; r.nx = T_CNT; end
          else r.nx = T_FIN;
        end else begin
          r.nx = (c == 8'd0) ? T_FIN : T_DATA;
        end
      end
      T_CNT:   begin r.st = WDAT; r.v = c - 8'd1; r.nx = T_PFIN; end
      T_PFIN:  begin r.st = POLL; r.nx = T_FIN; end
      default: r.st = FIN;
    endcase
    return r;
  endfunction

  // Stream bytes consume the counter as their data write completes.
  assign cnt_eff = (state_q == WDAT && step_q == T_AFTER && !op_q) ? cnt_q - 8'd1 : cnt_q;
  assign g       = go(step_q, op_q, addr_q, cnt_eff, fill_q);

  // State and bus registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;    step_q <= T_FIN;  val_q <= '0;
      cs_q    <= 1'b0;    rs_q   <= 1'b0;   we_q  <= 1'b0; dout_q <= '0;
      cnt_q   <= '0;      poll_q <= '0;     op_q  <= 1'b0;
      addr_q  <= '0;      fill_q <= '0;     err_q <= 1'b0;
    end else begin
      state_q <= state_d; step_q <= step_d; val_q <= val_d;
      cs_q    <= cs_d;    rs_q   <= rs_d;   we_q  <= we_d; dout_q <= dout_d;
      cnt_q   <= cnt_d;   poll_q <= poll_d; op_q  <= op_d;
      addr_q  <= addr_d;  fill_q <= fill_d; err_q <= err_d;
    end
  end

  // Next state: access states raise cs for one access, drop it on the strobe and advance.
  always_comb begin
    state_d = state_q; step_d = step_q; val_d = val_q;
    cs_d = cs_q; rs_d = rs_q; we_d = we_q; dout_d = dout_q;
    cnt_d = cnt_q; poll_d = poll_q; op_d = op_q; addr_d = addr_q; fill_d = fill_q;
    err_d = 1'b0;
    pop   = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d    = bus.cmd_op;
        addr_d  = bus.cmd_addr;
        cnt_d   = bus.cmd_count;
        fill_d  = bus.cmd_fill;
        poll_d  = '0;
        step_d  = T_SEL18;
        state_d = (bus.cmd_count == 8'd0) ? FIN : POLL;
      end
      FIN: state_d = IDLE;
      FETCH: if (bus.in_valid) begin
        pop     = 1'b1;
        val_d   = bus.in_data;
        state_d = WDAT;
      end
      default: begin
        if (!cs_q) begin
          cs_d   = 1'b1;
          rs_d   = (state_q == WDAT);
          we_d   = (state_q != POLL);
          dout_d = (state_q == POLL) ? 8'h00 : val_q;
        end else if (bus.bus_strobe) begin
          cs_d = 1'b0; rs_d = 1'b0; we_d = 1'b0; dout_d = 8'h00;
          if (state_q == POLL && !bus.vdc_din[7]) begin
            if (({1'b0, poll_q} + 17'd1) >= 17'(POLL_LIMIT)) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              poll_d = poll_q + 16'd1;
            end
          end else begin
            if (state_q == POLL) poll_d = '0;
            cnt_d   = cnt_eff;
            state_d = g.st;
            step_d  = g.nx;
            val_d   = g.v;
          end
        end
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.error     = err_q;
  assign bus.in_ready  = pop;
  assign bus.vdc_cs    = cs_q;
  assign bus.vdc_rs    = rs_q;
  assign bus.vdc_we    = we_q;
  assign bus.vdc_dout  = dout_q;

endmodule

// File: tb/tb_vdc_hostwriter.sv
// Bench for vdc_hostwriter: a VDC port model (register select, UA, RAM, fill)
// plus a command-level reference for expected writes, polls and RAM contents.
`timescale 1ns/1ps
module tb_vdc_hostwriter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vdc_hostwriter_if bus();
  vdc_hostwriter #(.POLL_LIMIT(255)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_chk = 0, n_fail = 0;
  logic [7:0]  ram [0:65535];
  logic [4:0]  vsel = '0;
  logic [15:0] ua = '0;
  logic [7:0]  last = '0;
  logic [8:0]  wlog[$];
  logic [7:0]  sq[$];
  int reads = 0, done_cnt = 0, err_cnt = 0, accepts = 0, gap_viol = 0, spur_rdy = 0;
  int cyc = 0, accept_cyc = 0, done_cyc = 0, nr_left = 0, strobe_mode = 0;
  bit prev_cmp = 1'b0;

  typedef struct {
    logic        op;
    logic [15:0] addr;
    logic [7:0]  count;
    logic [7:0]  fill;
    int          nready;
    int          exp_w;
    int          exp_r;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // VDC register port as seen from outside.
  task automatic vdc_write(input logic rs, input logic [7:0] d);
    if (!rs) vsel = d[4:0];
    else case (vsel)
      5'd18: ua[15:8] = d;
      5'd19: ua[7:0]  = d;
      5'd31: begin ram[ua] = d; last = d; ua = ua + 16'd1; end
      5'd30: for (int i = 0; i < int'(d); i++) begin ram[ua] = last; ua = ua + 16'd1; end
      default: ;
    endcase
  endtask

  // Drive strobe/status/stream each negedge, then observe the cycle just set up.
  always @(negedge clk) begin
    cyc++;
    bus.bus_strobe = (strobe_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.vdc_din    = {(nr_left == 0), 7'($urandom_range(0, 127))};
    if (sq.size() > 0) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = sq[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
    #1;
    if (!reset_n) prev_cmp = 1'b0;
    else begin
      if (prev_cmp && bus.vdc_cs) gap_viol++;
      prev_cmp = bus.vdc_cs && bus.bus_strobe;
      if (prev_cmp) begin
        if (bus.vdc_we) begin
          wlog.push_back({bus.vdc_rs, bus.vdc_dout});
          vdc_write(bus.vdc_rs, bus.vdc_dout);
        end else begin
          reads++;
          if (nr_left > 0) nr_left--;
        end
      end
      if (bus.in_ready) begin
        if (bus.in_valid) void'(sq.pop_front());
        else spur_rdy++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin accepts++; accept_cyc = cyc; end
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (bus.error) err_cnt++;
    end
  end

  // Reference: the register-port writes a command must produce.
  task automatic model_writes(input logic op, input logic [15:0] a, input logic [7:0] n,
                              input logic [7:0] f, input logic [7:0] b[$], output logic [8:0] q[$]);
    q = {};
    if (n == 8'd0) return;
    q.push_back({1'b0, 8'd18}); q.push_back({1'b1, a[15:8]});
    q.push_back({1'b0, 8'd19}); q.push_back({1'b1, a[7:0]});
    q.push_back({1'b0, 8'd31});
    if (!op) begin
      foreach (b[i]) q.push_back({1'b1, b[i]});
    end else begin
      q.push_back({1'b1, f});
      if (n > 8'd1) begin q.push_back({1'b0, 8'd30}); q.push_back({1'b1, n - 8'd1}); end
    end
  endtask

  // Reference: status reads = one per poll step plus injected not-ready reads.
  function automatic int model_reads(logic op, logic [7:0] n, int nready);
    if (n == 8'd0) return 0;
    return (op ? 3 : int'(n) + 2) + nready;
  endfunction

  task automatic run_cmd(input logic op, input logic [15:0] a, input logic [7:0] n,
                         input logic [7:0] f, input int bound, output int nd, output int ne);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_count = n; bus.cmd_fill = f;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < bound; i++) begin
      #2;
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    nd = done_cnt - d0;
    ne = err_cnt - e0;
  endtask

  task automatic exec(input string nm, input logic op, input logic [15:0] a, input logic [7:0] n,
                      input logic [7:0] f, input logic [7:0] b[$], input int nready,
                      input int exp_w, input int exp_r);
    logic [8:0] eq[$];
    logic [7:0] ev;
    int nd, ne;
    nr_left = nready;
    wlog.delete();
    reads = 0;
    for (int i = 0; i < int'(n); i++) begin
      ev = op ? f : b[i];
      ram[a + 16'(i)] = ~ev;
    end
    if (!op) foreach (b[i]) sq.push_back(b[i]);
    model_writes(op, a, n, f, b, eq);
    run_cmd(op, a, n, f, 4000, nd, ne);
    chk({nm, " done pulses"}, 32'(nd), 32'd1);
    chk({nm, " error pulses"}, 32'(ne), 32'd0);
    chk({nm, " write count"}, 32'(wlog.size()), 32'(exp_w));
    for (int i = 0; i < eq.size() && i < wlog.size(); i++)
      chk($sformatf("%s write%0d", nm, i), 32'(wlog[i]), 32'(eq[i]));
    chk({nm, " status reads"}, 32'(reads), 32'(exp_r));
    for (int i = 0; i < int'(n); i++) begin
      ev = op ? f : b[i];
      chk($sformatf("%s ram+%0d", nm, i), 32'(ram[a + 16'(i)]), 32'(ev));
    end
    if (!op) chk({nm, " stream drained"}, 32'(sq.size()), 32'd0);
  endtask

  initial begin
    vec_t vt[6];
    logic [7:0] b[$];
    logic [8:0] eq[$];
    logic [8:0] tmp;
    int nd, ne, a0, cs_hi, rdy_hi, w, d0, e0;
    logic op;
    logic [15:0] a;
    logic [7:0] n, f;
    int nr;

    vt[0] = '{1'b0, 16'h1234, 8'd3,  8'h00, 0, 8, 5};
    vt[1] = '{1'b1, 16'h0800, 8'd10, 8'h20, 0, 8, 3};
    vt[2] = '{1'b1, 16'h4000, 8'd1,  8'h55, 5, 6, 8};
    vt[3] = '{1'b0, 16'h2000, 8'd0,  8'h00, 0, 0, 0};
    vt[4] = '{1'b0, 16'hFFFF, 8'd1,  8'h00, 0, 6, 3};
    vt[5] = '{1'b1, 16'h0100, 8'd2,  8'h7E, 2, 8, 5};

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_addr = '0; bus.cmd_count = '0;
    bus.cmd_fill = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.bus_strobe = 1'b0; bus.vdc_din = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset cs", 32'(bus.vdc_cs), 32'd0);
    chk("reset rs/we/dout", {22'd0, bus.vdc_rs, bus.vdc_we, bus.vdc_dout}, 32'd0);
    chk("reset done/error/in_ready", {29'd0, bus.done, bus.error, bus.in_ready}, 32'd0);
    reset_n = 1'b1;

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      b.delete();
      for (int i = 0; i < int'(vt[v].count); i++) begin
        tmp = 9'h0A1 + 9'(i) * 9'h011;
        b.push_back(tmp[7:0]);
      end
      exec($sformatf("vec%0d", v), vt[v].op, vt[v].addr, vt[v].count, vt[v].fill, b,
           vt[v].nready, vt[v].exp_w, vt[v].exp_r);
    end

    // count=0: done exactly one cycle after accept
    run_cmd(1'b1, 16'h5555, 8'd0, 8'h00, 100, nd, ne);
    chk("count0 done latency", 32'(done_cyc - accept_cyc), 32'd1);

    // Stream withheld mid-command: bus idle, no pop, busy ignores cmd_valid
    strobe_mode = 0; nr_left = 0; wlog.delete(); reads = 0;
    b = '{8'h5A, 8'h6B, 8'h7C};
    for (int i = 0; i < 3; i++) ram[16'h3000 + 16'(i)] = 8'h00;
    sq.push_back(b[0]);
    a0 = accepts;
    fork
      run_cmd(1'b0, 16'h3000, 8'd3, 8'h00, 4000, nd, ne);
      begin
        w = 0; cs_hi = 0; rdy_hi = 0;
        while (sq.size() > 0 && w < 1000) begin @(negedge clk); w++; end
        repeat (10) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1; bus.cmd_count = 8'd7;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk); #2;
          if (bus.vdc_cs) cs_hi++;
          if (bus.in_ready) rdy_hi++;
        end
        bus.cmd_valid = 1'b0;
        chk("withhold cs idle cycles", 32'(cs_hi), 32'd0);
        chk("withhold in_ready cycles", 32'(rdy_hi), 32'd0);
        sq.push_back(b[1]); sq.push_back(b[2]);
      end
    join
    chk("withhold done", 32'(nd), 32'd1);
    chk("withhold accepts", 32'(accepts - a0), 32'd1);
    model_writes(1'b0, 16'h3000, 8'd3, 8'h00, b, eq);
    chk("withhold write count", 32'(wlog.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < wlog.size(); i++)
      chk($sformatf("withhold write%0d", i), 32'(wlog[i]), 32'(eq[i]));
    for (int i = 0; i < 3; i++)
      chk($sformatf("withhold ram+%0d", i), 32'(ram[16'h3000 + 16'(i)]), 32'(b[i]));

    // Status never ready: abort after POLL_LIMIT reads
    nr_left = 1000000; wlog.delete(); reads = 0;
    run_cmd(1'b1, 16'h0000, 8'd4, 8'h11, 3000, nd, ne);
    chk("timeout error pulse", 32'(ne), 32'd1);
    chk("timeout no done", 32'(nd), 32'd0);
    chk("timeout status reads", 32'(reads), 32'd255);
    chk("timeout no writes", 32'(wlog.size()), 32'd0);
    chk("timeout cmd_ready", 32'(bus.cmd_ready), 32'd1);
    nr_left = 0;

    // Randomized commands against the reference
    for (int k = 0; k < 20; k++) begin
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      n  = 8'($urandom_range(0, 12));
      f  = 8'($urandom);
      nr = $urandom_range(0, 6);
      strobe_mode = $urandom_range(0, 1);
      b.delete();
      if (!op) for (int i = 0; i < int'(n); i++) b.push_back(8'($urandom));
      model_writes(op, a, n, f, b, eq);
      exec($sformatf("rnd%0d", k), op, a, n, f, b, nr, eq.size(), model_reads(op, n, nr));
    end
    strobe_mode = 0;

    // Reset in the middle of a WRITE
    for (int i = 0; i < 4; i++) sq.push_back(8'(8'h10 + i));
    @(negedge clk);
    bus.cmd_op = 1'b0; bus.cmd_addr = 16'h6000; bus.cmd_count = 8'd4; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 50 && !bus.vdc_cs; i++) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    chk("midreset cs high before reset", 32'(bus.vdc_cs), 32'd1);
    reset_n = 1'b0;
    sq.delete();
    @(negedge clk); #2;
    chk("midreset cs", 32'(bus.vdc_cs), 32'd0);
    chk("midreset rs/we/dout", {22'd0, bus.vdc_rs, bus.vdc_we, bus.vdc_dout}, 32'd0);
    chk("midreset cmd_ready/busy", {30'd0, bus.cmd_ready, bus.busy}, 32'd2);
    chk("midreset done/error/in_ready", {29'd0, bus.done, bus.error, bus.in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk); #2;
    chk("midreset no done", 32'(done_cnt - d0), 32'd0);
    chk("midreset no error", 32'(err_cnt - e0), 32'd0);
    chk("midreset idle after", {30'd0, bus.vdc_cs, bus.cmd_ready}, 32'd1);

    chk("idle gap violations", 32'(gap_viol), 32'd0);
    chk("in_ready without in_valid", 32'(spur_rdy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: test did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
